// File: rtl/game2048_engine_n_if.sv
// Board-side bundle of the 2048 engine: buttons, debug load, board/score/status.
// master drives buttons and load; slave is the engine.
interface game2048_engine_n_if #(
    parameter int N  = 4,
    parameter int TW = 4,
    parameter int SW = 20
);
    logic              mov_right;
    logic              mov_left;
    logic              mov_up;
    logic              mov_down;
    logic              load_en;
    logic [N*N*TW-1:0] load_board;
    logic [N*N*TW-1:0] board;
    logic [SW-1:0]     score;
    logic              busy;
    logic              win;
    logic              defeat;

    modport master (
        output mov_right, mov_left, mov_up, mov_down,
        output load_en, load_board,
        input  board, score, busy, win, defeat
    );

    modport slave (
        input  mov_right, mov_left, mov_up, mov_down,
        input  load_en, load_board,
        output board, score, busy, win, defeat
    );
endinterface

// File: rtl/game2048_engine_n.sv
// 2048 engine for an N x N board of tile exponents.
// Button sync, one line merged per cycle, LFSR tile spawn, win/defeat check.
module game2048_engine_n #(
    parameter int          N       = 4,
    parameter int          TW      = 4,
    parameter int          WIN_EXP = 11,
    parameter int          SW      = 20,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input logic                clk,
    input logic                reset,
    game2048_engine_n_if.slave bus
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int LW = $clog2(N);
    localparam int AW = SW + 3;

    localparam logic [TW-1:0] TMAX    = '1;
    localparam logic [SW-1:0] SMAX    = '1;
    localparam logic [TW-1:0] TW_ONE  = 1;
    localparam logic [LW:0]   WR_ONE  = 1;
    localparam logic [LW-1:0] LN_ONE  = 1;
    localparam logic [IW-1:0] IDX_ONE = 1;

    typedef enum logic [2:0] {
        S_WAIT_START,
        S_IDLE,
        S_MOVE,
        S_SPAWN,
        S_CHECK,
        S_GAME_OVER
    } state_t;

    typedef enum logic [1:0] {
        D_RIGHT,
        D_LEFT,
        D_UP,
        D_DOWN
    } dir_t;

    // Button pipeline, bit order {down, up, left, right}
    logic [3:0] btn;
    logic [3:0] btn_s1_q, btn_s2_q, btn_s3_q, edge_q;
    logic       press;
    dir_t       press_dir;

    logic [15:0] lfsr_q;

    state_t                state_q, state_d;
    dir_t                  dir_q, dir_d;
    logic [LW-1:0]         ln_q, ln_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic                  spn_q, spn_d;
    logic                  init_q, init_d;
    logic                  chg_q, chg_d;
    logic [NN-1:0][TW-1:0] board_q, board_d;
    logic [SW-1:0]         score_q, score_d;
    logic                  win_q, win_d;
    logic                  defeat_q, defeat_d;

    // Current line, ordered from the leading edge of the move
    int            li;
    logic [IW-1:0] pos  [N];
    logic [TW-1:0] lin  [N];
    logic [TW-1:0] cmp  [N+1];
    logic [TW-1:0] lout [N];
    logic [LW:0]   wr;
    logic          skip;
    logic [AW-1:0] ladd;
    logic          lsat;
    logic          lchg;
    logic [AW-1:0] score_sum;
    logic [SW-1:0] score_mv;

    logic          full, pair, anywin;
    logic [IW-1:0] start_idx;
    logic [TW-1:0] spawn_val;

    assign btn = {bus.mov_down, bus.mov_up, bus.mov_left, bus.mov_right};

    // Two-flop synchroniser, then a registered falling-edge pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1_q <= '1;
            btn_s2_q <= '1;
            btn_s3_q <= '1;
            edge_q   <= '0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            edge_q   <= btn_s3_q & ~btn_s2_q;
        end
    end

    // Free-running Galois LFSR, taps 16,14,13,11
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Simultaneous presses resolve right > left > up > down
    always_comb begin
        press     = |edge_q;
        press_dir = D_DOWN;
        if (edge_q[0]) begin
            press_dir = D_RIGHT;
        end else if (edge_q[1]) begin
            press_dir = D_LEFT;
        end else if (edge_q[2]) begin
            press_dir = D_UP;
        end
    end

    // Map the line being moved onto board cells, leading edge first
    always_comb begin
        if (dir_q == D_RIGHT || dir_q == D_DOWN) begin
            li = N - 1 - int'(ln_q);
        end else begin
            li = int'(ln_q);
        end
        for (int k = 0; k < N; k++) begin
            unique case (dir_q)
                D_LEFT:  pos[k] = IW'(li * N + k);
                D_RIGHT: pos[k] = IW'(li * N + (N - 1 - k));
                D_UP:    pos[k] = IW'(k * N + li);
                default: pos[k] = IW'((N - 1 - k) * N + li);
            endcase
            lin[k] = board_q[pos[k]];
        end
    end

    // Compact, then merge pairs once each from the leading edge
    always_comb begin
        for (int k = 0; k <= N; k++) begin
            cmp[k] = '0;
        end
        wr = '0;
        for (int k = 0; k < N; k++) begin
            if (lin[k] != '0) begin
                cmp[wr] = lin[k];
                wr      = wr + WR_ONE;
            end
        end
        for (int k = 0; k < N; k++) begin
            lout[k] = '0;
        end
        wr   = '0;
        skip = 1'b0;
        ladd = '0;
        lsat = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[k] != '0) begin
                if (cmp[k] == cmp[k+1] && cmp[k] != TMAX) begin
                    lout[wr] = cmp[k] + TW_ONE;
                    if (int'(cmp[k]) + 1 >= SW) begin
                        lsat = 1'b1;
                    end else begin
                        ladd = ladd + (AW'(1) << (int'(cmp[k]) + 1));
                    end
                    skip = 1'b1;
                end else begin
                    lout[wr] = cmp[k];
                end
                wr = wr + WR_ONE;
            end
        end
        lchg = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (lout[k] != lin[k]) begin
                lchg = 1'b1;
            end
        end
    end

    assign score_sum = AW'(score_q) + ladd;
    assign score_mv  = (lsat || score_sum > AW'(SMAX)) ? SMAX : score_sum[SW-1:0];

    // Whole-board status: empty cells, equal neighbours, winning tile
    always_comb begin
        full   = 1'b1;
        pair   = 1'b0;
        anywin = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (board_q[IW'(r * N + c)] == '0) begin
                    full = 1'b0;
                end
                if (int'(board_q[IW'(r * N + c)]) >= WIN_EXP) begin
                    anywin = 1'b1;
                end
                if (c < N - 1 && board_q[IW'(r * N + c)] ==
                    board_q[IW'((c < N - 1) ? r * N + c + 1 : r * N + c)]) begin
                    pair = 1'b1;
                end
                if (r < N - 1 && board_q[IW'(r * N + c)] ==
                    board_q[IW'((r < N - 1) ? (r + 1) * N + c : r * N + c)]) begin
                    pair = 1'b1;
                end
            end
        end
    end

    assign start_idx = IW'(lfsr_q % 16'(NN));
    assign spawn_val = (lfsr_q[3:0] == 4'd0) ? TW'(2) : TW'(1);

    // Next state: start, move line by line, spawn scan, end-of-turn check
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        ln_d     = ln_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        spn_d    = spn_q;
        init_d   = init_q;
        chg_d    = chg_q;
        board_d  = board_q;
        score_d  = score_q;
        win_d    = win_q;
        defeat_d = defeat_q;
        unique case (state_q)
            S_WAIT_START: begin
                if (press) begin
                    state_d = S_SPAWN;
                    init_d  = 1'b1;
                    spn_d   = 1'b1;
                    idx_d   = start_idx;
                    cnt_d   = '0;
                end
            end
            S_IDLE: begin
                if (press) begin
                    state_d = S_MOVE;
                    dir_d   = press_dir;
                    ln_d    = '0;
                    chg_d   = 1'b0;
                end
            end
            S_MOVE: begin
                for (int k = 0; k < N; k++) begin
                    board_d[pos[k]] = lout[k];
                end
                score_d = score_mv;
                chg_d   = chg_q | lchg;
                if (ln_q == LW'(N - 1)) begin
                    if (chg_q | lchg) begin
                        state_d = S_SPAWN;
                        init_d  = 1'b0;
                        spn_d   = 1'b0;
                        idx_d   = start_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else begin
                    ln_d = ln_q + LN_ONE;
                end
            end
            S_SPAWN: begin
                if (board_q[idx_q] == '0 || cnt_q == IW'(NN - 1)) begin
                    if (board_q[idx_q] == '0) begin
                        board_d[idx_q] = spawn_val;
                    end
                    if (spn_q) begin
                        spn_d = 1'b0;
                        idx_d = start_idx;
                        cnt_d = '0;
                    end else if (init_q) begin
                        init_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end else begin
                    idx_d = (idx_q == IW'(NN - 1)) ? '0 : idx_q + IDX_ONE;
                    cnt_d = cnt_q + IDX_ONE;
                end
            end
            S_CHECK: begin
                win_d = win_q | anywin;
                if (full && !pair) begin
                    defeat_d = 1'b1;
                    state_d  = S_GAME_OVER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAME_OVER: begin
                state_d = S_GAME_OVER;
            end
            default: begin
                state_d = S_WAIT_START;
            end
        endcase
        // A debug load wins over a same-cycle press; a line in flight is kept intact
        if (bus.load_en && state_q != S_MOVE) begin
            board_d  = bus.load_board;
            win_d    = 1'b0;
            defeat_d = 1'b0;
            init_d   = 1'b0;
            spn_d    = 1'b0;
            state_d  = S_IDLE;
        end
    end

    // Engine state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_WAIT_START;
            dir_q    <= D_RIGHT;
            ln_q     <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            spn_q    <= 1'b0;
            init_q   <= 1'b0;
            chg_q    <= 1'b0;
            board_q  <= '0;
            score_q  <= '0;
            win_q    <= 1'b0;
            defeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            ln_q     <= ln_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            spn_q    <= spn_d;
            init_q   <= init_d;
            chg_q    <= chg_d;
            board_q  <= board_d;
            score_q  <= score_d;
            win_q    <= win_d;
            defeat_q <= defeat_d;
        end
    end

    assign bus.board  = board_q;
    assign bus.score  = score_q;
    assign bus.win    = win_q;
    assign bus.defeat = defeat_q;
    assign bus.busy   = (state_q == S_MOVE) || (state_q == S_SPAWN) || (state_q == S_CHECK);

endmodule
